// File: rtl/ble_cmd_parser_if.sv
// Byte stream from the UART receiver into the BLE command parser, and the decoded
// gameplay controls and error counters coming back out.
interface ble_cmd_parser_if #(
    parameter int unsigned CNT_W = 8
);
    logic [7:0]       byte_in;
    logic             byte_valid_in;
    logic             pkt_valid_out;
    logic [7:0]       cmd_out;
    logic [15:0]      payload_out;
    logic             swing_pulse_out;
    logic [15:0]      swing_power_out;
    logic             pan_left_out;
    logic             pan_right_out;
    logic             new_game_out;
    logic [CNT_W-1:0] chk_err_cnt_out;
    logic [CNT_W-1:0] timeout_cnt_out;

    modport master (
        output byte_in, byte_valid_in,
        input  pkt_valid_out, cmd_out, payload_out, swing_pulse_out, swing_power_out,
        input  pan_left_out, pan_right_out, new_game_out, chk_err_cnt_out, timeout_cnt_out
    );

    modport slave (
        input  byte_in, byte_valid_in,
        output pkt_valid_out, cmd_out, payload_out, swing_pulse_out, swing_power_out,
        output pan_left_out, pan_right_out, new_game_out, chk_err_cnt_out, timeout_cnt_out
    );
endinterface

// File: rtl/ble_cmd_parser.sv
// Assembles 5-byte BLE command packets (SYNC, CMD, PL_HI, PL_LO, CHK), checks the
// XOR checksum and drives the gameplay controls from good packets.
module ble_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 742500,
    parameter int unsigned CNT_W          = 8
) (
    input logic             clk_in,
    input logic             rst_in_n,
    ble_cmd_parser_if.slave bus
);
    localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      CMD_SWING    = 8'h01;
    localparam logic [7:0]      CMD_PAN      = 8'h02;
    localparam logic [7:0]      CMD_NEW_GAME = 8'h03;

    typedef enum logic [2:0] {StIdle, StCmd, StHi, StLo, StChk} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cmd_q, hi_q, lo_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pkt_good, pkt_bad, timeout;

    logic             pkt_valid_q, swing_pulse_q, new_game_q, pan_left_q, pan_right_q;
    logic [7:0]       cmd_out_q;
    logic [15:0]      payload_q, swing_power_q;
    logic [CNT_W-1:0] chk_err_q, timeout_cnt_q;

    always_comb begin
        state_d  = state_q;
        pkt_good = 1'b0;
        pkt_bad  = 1'b0;
        timeout  = 1'b0;
        if (bus.byte_valid_in) begin
            // A byte on the limit cycle takes priority over the timeout.
            unique case (state_q)
                StIdle:  if (bus.byte_in == SYNC_BYTE) state_d = StCmd;
                StCmd:   state_d = StHi;
                StHi:    state_d = StLo;
                StLo:    state_d = StChk;
                StChk: begin
                    state_d = StIdle;
                    if (bus.byte_in == (cmd_q ^ hi_q ^ lo_q)) pkt_good = 1'b1;
                    else                                      pkt_bad  = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && tmo_q == TMO_LAST) begin
            timeout = 1'b1;
            state_d = StIdle;
        end
    end

    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.byte_valid_in || state_q == StIdle || timeout) tmo_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            cmd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (bus.byte_valid_in) begin
                if (state_q == StCmd) cmd_q <= bus.byte_in;
                if (state_q == StHi)  hi_q  <= bus.byte_in;
                if (state_q == StLo)  lo_q  <= bus.byte_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pkt_valid_q   <= 1'b0;
            swing_pulse_q <= 1'b0;
            new_game_q    <= 1'b0;
            pan_left_q    <= 1'b0;
            pan_right_q   <= 1'b0;
            cmd_out_q     <= '0;
            payload_q     <= '0;
            swing_power_q <= '0;
            chk_err_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            pkt_valid_q   <= pkt_good;
            swing_pulse_q <= pkt_good && cmd_q == CMD_SWING;
            new_game_q    <= pkt_good && cmd_q == CMD_NEW_GAME;
            if (pkt_good) begin
                cmd_out_q <= cmd_q;
                payload_q <= {hi_q, lo_q};
                if (cmd_q == CMD_SWING) swing_power_q <= {hi_q, lo_q};
                if (cmd_q == CMD_PAN) begin
                    pan_left_q  <= lo_q[0];
                    pan_right_q <= lo_q[1];
                end
            end
            // Link loss stops the camera.
            if (timeout) begin
                pan_left_q  <= 1'b0;
                pan_right_q <= 1'b0;
            end
            if (pkt_bad && chk_err_q != '1)     chk_err_q     <= chk_err_q + CNT_W'(1);
            if (timeout && timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pkt_valid_out   = pkt_valid_q;
    assign bus.cmd_out         = cmd_out_q;
    assign bus.payload_out     = payload_q;
    assign bus.swing_pulse_out = swing_pulse_q;
    assign bus.swing_power_out = swing_power_q;
    assign bus.pan_left_out    = pan_left_q;
    assign bus.pan_right_out   = pan_right_q;
    assign bus.new_game_out    = new_game_q;
    assign bus.chk_err_cnt_out = chk_err_q;
    assign bus.timeout_cnt_out = timeout_cnt_q;
endmodule
